// File: rtl/buff_reduce_fsm.sv
// rtl/buff_reduce_fsm.sv - snapshot a burst buffer, serially reduce it to sum/max, hand off by valid/ack
// Frees the read FSM at snapshot time; a rise that cannot be accepted is reported on Drop.
module buff_reduce_fsm #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16,
  parameter int ACC_W  = 24
) (
  input  logic                     Clk1,
  input  logic                     Rst,
  input  logic [WORD_W*NWORDS-1:0] DataBuff,
  input  logic                     done_vld,
  output logic                     Busy,
  output logic [ACC_W-1:0]         Sum,
  output logic [WORD_W-1:0]        Max,
  output logic                     ResVld,
  input  logic                     ResAck,
  output logic                     Drop
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state, state_n;
  logic [WORD_W*NWORDS-1:0]   snap, snap_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic [ACC_W-1:0]           sum_n;
  logic [WORD_W-1:0]          max_n;
  logic                       resvld_n, drop_n;
  logic                       done_q;
  logic                       rise, capture;
  logic [WORD_W-1:0]          w;

  assign rise = done_vld & ~done_q;
  assign w    = snap[int'(idx)*WORD_W +: WORD_W];

  always_ff @(posedge Clk1) begin
    if (Rst) begin
      state  <= IDLE;
      snap   <= '0;
      idx    <= '0;
      Sum    <= '0;
      Max    <= '0;
      ResVld <= 1'b0;
      Drop   <= 1'b0;
      Busy   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      snap   <= snap_n;
      idx    <= idx_n;
      Sum    <= sum_n;
      Max    <= max_n;
      ResVld <= resvld_n;
      Drop   <= drop_n;
      Busy   <= (state_n != IDLE);
      done_q <= done_vld;
    end
  end

  always_comb begin
    state_n  = state;
    snap_n   = snap;
    idx_n    = idx;
    sum_n    = Sum;
    max_n    = Max;
    resvld_n = ResVld;
    drop_n   = 1'b0;
    capture  = 1'b0;

    case (state)
      IDLE: capture = rise;
      RUN: begin
        drop_n = rise;
        sum_n  = Sum + ACC_W'(w);
        if (w > Max) max_n = w;
        idx_n  = idx + 1'b1;
        if (idx == IDX_W'(NWORDS - 1)) begin
          resvld_n = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        if (ResAck) begin
          resvld_n = 1'b0;
          state_n  = IDLE;
          capture  = rise;
        end else begin
          drop_n = rise;
        end
      end
      default: state_n = IDLE;
    endcase

    // New buffer restarts the reduction; shared by IDLE and the ack+rise path in DONE
    if (capture) begin
      snap_n  = DataBuff;
      sum_n   = '0;
      max_n   = '0;
      idx_n   = '0;
      state_n = RUN;
    end
  end

endmodule

// File: tb/tb_buff_reduce_fsm.sv
// tb/tb_buff_reduce_fsm.sv - self-checking bench for buff_reduce_fsm
// Transaction-level model predicts handshake outputs each cycle; literals pin the directed cases.
module tb_buff_reduce_fsm;

  logic         Clk1 = 1'b0;
  logic         Rst = 1'b1;
  logic [255:0] DataBuff = '0;
  logic         done_vld = 1'b0;
  logic         Busy;
  logic [23:0]  Sum;
  logic [15:0]  Max;
  logic         ResVld;
  logic         ResAck = 1'b0;
  logic         Drop;

  buff_reduce_fsm dut (
    .Clk1(Clk1), .Rst(Rst), .DataBuff(DataBuff), .done_vld(done_vld),
    .Busy(Busy), .Sum(Sum), .Max(Max), .ResVld(ResVld), .ResAck(ResAck), .Drop(Drop)
  );

  always #5 Clk1 = ~Clk1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [255:0] ramp(input int base);
    logic [255:0] b = '0;
    for (int k = 0; k < 16; k++) b[k*16 +: 16] = 16'(base + k);
    return b;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] b = '0;
    for (int k = 0; k < 16; k++) b[k*16 +: 16] = v;
    return b;
  endfunction

  function automatic logic [31:0] exp_sum(input logic [255:0] b);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(b[k*16 +: 16]);
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_max(input logic [255:0] b);
    int m = 0;
    for (int k = 0; k < 16; k++) if (int'(b[k*16 +: 16]) > m) m = int'(b[k*16 +: 16]);
    return 32'(m);
  endfunction

  // Model: a buffer accepted now yields its sum/max 16 cycles later and is held until acked
  int          m_phase = 0;
  int          m_left = 0;
  bit          m_live = 0, m_vld = 0, m_drop = 0, m_dq = 0, m_rise;
  logic [31:0] m_sum = 0, m_max = 0, p_sum = 0, p_max = 0;

  always @(posedge Clk1) begin
    if (Rst) begin
      m_phase = 0; m_vld = 0; m_drop = 0; m_dq = 0; m_live = 1;
    end else begin
      m_rise = done_vld && !m_dq;
      m_dq   = done_vld;
      m_drop = 0;
      if (m_phase == 0) begin
        if (m_rise) begin p_sum = exp_sum(DataBuff); p_max = exp_max(DataBuff); m_left = 16; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (m_rise) m_drop = 1;
        m_left--;
        if (m_left == 0) begin m_phase = 2; m_vld = 1; m_sum = p_sum; m_max = p_max; end
      end else begin
        if (ResAck) begin
          m_vld = 0;
          if (m_rise) begin p_sum = exp_sum(DataBuff); p_max = exp_max(DataBuff); m_left = 16; m_phase = 1; end
          else m_phase = 0;
        end else if (m_rise) m_drop = 1;
      end
    end
  end

  int drop_cnt = 0;
  int res_cnt = 0;
  bit prev_vld = 0;

  always @(negedge Clk1) begin
    if (m_live) begin
      check("busy", {31'b0, Busy}, {31'b0, m_phase != 0});
      check("resvld", {31'b0, ResVld}, {31'b0, m_vld});
      check("drop", {31'b0, Drop}, {31'b0, m_drop});
      if (m_vld) begin
        check("sum", {8'b0, Sum}, m_sum);
        check("max", {16'b0, Max}, m_max);
      end
      if (Drop === 1'b1) drop_cnt++;
      if (ResVld === 1'b1 && !prev_vld) res_cnt++;
      prev_vld = (ResVld === 1'b1);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge Clk1);
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (ResVld !== 1'b1 && n < 40) begin tick(); n++; end
    if (ResVld !== 1'b1) check("vld_timeout", {31'b0, ResVld}, 32'd1);
  endtask

  task automatic ack();
    ResAck = 1'b1; done_vld = 1'b0;
    tick();
    ResAck = 1'b0;
  endtask

  int n;

  initial begin
    tick(2);
    Rst = 1'b0;
    check("rst_busy", {31'b0, Busy}, 0);
    check("rst_vld", {31'b0, ResVld}, 0);
    check("rst_sum", {8'b0, Sum}, 0);
    check("rst_max", {16'b0, Max}, 0);
    check("rst_drop", {31'b0, Drop}, 0);

    // 1: ramp 15..30, latency 17 negedges from drive
    DataBuff = ramp(15); done_vld = 1'b1;
    wait_vld(n);
    check("s1_lat", n, 17);
    check("s1_sum", {8'b0, Sum}, 32'd360);
    check("s1_max", {16'b0, Max}, 32'd30);
    ack();
    check("s1_idle", {31'b0, Busy}, 0);

    // 2: saturated words, then zeros
    DataBuff = fill(16'hFFFF); done_vld = 1'b1;
    wait_vld(n);
    check("s2_sum", {8'b0, Sum}, 32'h0FFFF0);
    check("s2_max", {16'b0, Max}, 32'hFFFF);
    ack();
    DataBuff = fill(16'h0000); done_vld = 1'b1;
    wait_vld(n);
    check("s2z_sum", {8'b0, Sum}, 0);
    check("s2z_max", {16'b0, Max}, 0);
    ack();

    // 3: level held 100 cycles -> one result only
    drop_cnt = 0; res_cnt = 0;
    DataBuff = ramp(1); done_vld = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (ResVld === 1'b1 && res_cnt == 1 && i < 30) ResAck = 1'b1;
      tick();
      ResAck = 1'b0;
    end
    check("s3_results", res_cnt, 1);
    check("s3_drops", drop_cnt, 0);
    check("s3_idle", {31'b0, Busy}, 0);
    done_vld = 1'b0; tick();

    // 4: second rise at E+5 is dropped, snapshot isolated
    drop_cnt = 0;
    DataBuff = ramp(15); done_vld = 1'b1;
    tick(); done_vld = 1'b0;
    tick(4);
    done_vld = 1'b1; DataBuff = fill(16'hFFFF);
    tick();
    check("s4_drop_hi", {31'b0, Drop}, 1);
    tick();
    check("s4_drop_lo", {31'b0, Drop}, 0);
    wait_vld(n);
    check("s4_sum", {8'b0, Sum}, 32'd360);
    check("s4_max", {16'b0, Max}, 32'd30);
    check("s4_drops", drop_cnt, 1);
    ack();

    // 5: ack together with a new rise in DONE
    DataBuff = ramp(15); done_vld = 1'b1;
    tick(); done_vld = 1'b0;
    wait_vld(n);
    drop_cnt = 0;
    DataBuff = fill(16'd2); done_vld = 1'b1; ResAck = 1'b1;
    tick();
    ResAck = 1'b0;
    check("s5_vld_lo", {31'b0, ResVld}, 0);
    check("s5_busy", {31'b0, Busy}, 1);
    check("s5_nodrop", {31'b0, Drop}, 0);
    wait_vld(n);
    check("s5_lat", n, 16);
    check("s5_sum", {8'b0, Sum}, 32'd32);
    check("s5_max", {16'b0, Max}, 32'd2);
    check("s5_drops", drop_cnt, 0);
    ack();

    // 6: reset mid-RUN, then a fresh full result
    DataBuff = ramp(15); done_vld = 1'b1;
    tick(); done_vld = 1'b0;
    tick(7);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("s6_busy", {31'b0, Busy}, 0);
    check("s6_vld", {31'b0, ResVld}, 0);
    check("s6_sum", {8'b0, Sum}, 0);
    check("s6_max", {16'b0, Max}, 0);
    check("s6_drop", {31'b0, Drop}, 0);
    done_vld = 1'b1;
    wait_vld(n);
    check("s6_lat", n, 17);
    check("s6_rsum", {8'b0, Sum}, 32'd360);
    check("s6_rmax", {16'b0, Max}, 32'd30);
    ack();
    tick(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
